result_stream_reader: RTL and testbench
=======================================

# result_stream_reader

Sink-side reader for the 64-bit result streams produced by signal processing: captures `data_in`/`data_in_valid` samples into a circular buffer and lets the Nios/HPS control side drain them through a 32-bit Avalon-MM slave. It is the reading end of the valid-only result stream. The stream has no backpressure, so the block has sticky overflow and underflow accounting.

## Interface
- `DEPTH`, 256: buffer entries; power of two, ≥ 4.
- `ADDR_W`, 8: log2(`DEPTH`).
- `clk`  in  1: single clock for all logic.
- `reset_n`  in  1: reset is synchronous and active-low.
- `enable`  in  1: capture enable; when low, incoming samples are ignored and not counted.
- `data_in`  in  64: result sample.
- `data_in_valid`  in  1: one-cycle qualifier per sample; no backpressure.
- `avs_address`  in  2: word select.
- `avs_read`  in  1: read strobe.
- `avs_readdata`  out  32: read data, fixed read latency of 1.
- `avs_write`  in  1: write strobe.
- `avs_writedata`  in  32: write data.
- `data_ready`  out  1: high while level ≥ `DEPTH`/2.

## Operation
- **Storage:** circular buffer with `wr_ptr`/`rd_ptr` of `ADDR_W` bits. `level` is `ADDR_W`+1 bits, range 0..`DEPTH`.
- **Push:** occurs when `enable && data_in_valid`.
  - If not full, write at `wr_ptr`, increment `wr_ptr` modulo `DEPTH`, and increment `accepted_cnt` (32-bit, wraps).
  - If full, drop the sample and set sticky `overflow`. `accepted_cnt` is unchanged.
- **Register map (reads):**
  - Address 0 (DATA_LO): if not empty, return `head[31:0]`, latch `head[63:32]` into `hi_hold`, and pop (`rd_ptr`+1). If empty, return 0, do not pop, and set sticky `underflow`.
  - Address 1 (DATA_HI): return `hi_hold`, with no side effect.
  - Address 2 (STATUS): bits[`ADDR_W`:0] = `level`, bit16 = empty, bit17 = full, bit18 = `overflow`, bit19 = `underflow`, all other bits 0.
  - Address 3 (COUNT): return `accepted_cnt`.
- **Register map (writes):**
  - Address 3, bit0 = 1: flush. Sets `rd_ptr`=`wr_ptr`=0, `level`=0, clears both flags, `accepted_cnt`=0, and `hi_hold`=0.
  - Address 3, bit1 = 1: clear `overflow` and `underflow` only.
  - Writes to other addresses are ignored.
- **Same-cycle push and pop:**
  - When not empty and not full, both take effect and `level` is unchanged.
  - When full, the pop frees an entry, so the push is accepted and `overflow` is not set.
  - When empty, there is no fall-through: the pop is an underflow and the push is accepted, giving `level`=1.
- **Flush priority:** a flush in the same cycle as a push discards the push.
- **Simultaneous strobes:** `avs_read` and `avs_write` asserted together is illegal; a write has priority and the read returns 0.
- **Reset values:** `avs_readdata`=0, `data_ready`=0, pointers, `level`, flags, `accepted_cnt` and `hi_hold` all 0.
- **Reset mid-operation:** discards all buffered content.

## Timing
- **Read latency:** `avs_readdata` is valid on the cycle after `avs_read` and holds until the next read.
- **Pop visibility:** a pop is visible in STATUS on the next read issued at least 1 cycle later.
- **Push to read:** a sample pushed in cycle N is readable by a DATA_LO read issued in cycle N+1; `level` is updated at the N+1 edge.
- **`data_ready`:** registered; updates 1 cycle after the `level` change.
- **Throughput:** sustains a push on every clock together with one Avalon read per clock.
- **Flag clears:** take effect at the edge after `avs_write`.

## Configuration
- **`RESULT_READER_DROP_OLDEST_EN` defined:** a push while full and without a same-cycle pop overwrites the oldest entry. `rd_ptr` and `wr_ptr` both advance, `level` stays `DEPTH`, `overflow` is set, and `accepted_cnt` increments.
- **Not defined:** the newest sample is dropped, as described under Operation.

## Test plan
- **Basic order:** reset, `enable`=1, push 0x1111_2222_3333_4444 and 0xAAAA_BBBB_CCCC_DDDD, then read addresses 0,1,0,1 → 0x33334444, 0x11112222, 0xCCCCDDDD, 0xAAAABBBB; STATUS `level`=0, empty=1.
- **Overflow:** push `DEPTH`+3 samples (values 0..258) → STATUS full=1, bit18=1, COUNT=256; the first DATA_LO read returns 0. With the macro defined, the first read returns 3 and COUNT=259.
- **Underflow and clear:** DATA_LO read when empty → 0, bit19=1. Write 0x2 to address 3 → bit19=0.
- **Simultaneous push/pop at full:** push on the same cycle as a DATA_LO read → `level` stays 256, `overflow`=0.
- **Enable gating and `data_ready`:** with `enable`=0, 10 valid samples → `level` 0, COUNT 0. With `enable`=1, pushing 128 samples → `data_ready` rises 1 cycle after the 128th push.
- **Reset and flush mid-stream:** with 50 entries buffered, assert `reset_n`=0 for 1 cycle → STATUS=0x10000 (empty only). Repeat using a flush write of 0x1 → same result.

Source files
------------

// File: rtl/result_stream_reader.sv
// Circular-buffer sink for a valid-only 64-bit result stream, drained through a 32-bit Avalon-MM slave.
// Optional macro RESULT_READER_DROP_OLDEST_EN: a full buffer overwrites its oldest entry instead of dropping the newest sample.
module result_stream_reader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        data_ready
);

  localparam logic [ADDR_W:0]   FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   HALF_LVL = FULL_LVL >> 1;
  localparam logic [ADDR_W:0]   LVL_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [31:0]       CNT_ONE  = 1;

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  logic [31:0]       accepted_cnt;
  logic [31:0]       hi_hold;

  logic        empty;
  logic        full;
  logic [63:0] head;
  logic        rd_evt;
  logic        flush;
  logic        clr_flags;
  logic        pop;
  logic        uflow;
  logic        push_req;
  logic        push;
  logic        drop;
  logic        overwrite;
  logic        wr_en;
  logic [31:0] status;
  logic [31:0] rd_mux;

  always_comb begin
    empty     = (level == '0);
    full      = (level == FULL_LVL);
    head      = mem[rd_ptr];
    // A read strobe coinciding with a write is treated as no read at all.
    rd_evt    = avs_read && !avs_write;
    flush     = avs_write && (avs_address == 2'd3) && avs_writedata[0];
    clr_flags = avs_write && (avs_address == 2'd3) && avs_writedata[1];
    pop       = rd_evt && (avs_address == 2'd0) && !empty;
    uflow     = rd_evt && (avs_address == 2'd0) && empty;
    push_req  = enable && data_in_valid && !flush;
    // A same-cycle pop frees a slot, so a full buffer still accepts the push.
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
`ifdef RESULT_READER_DROP_OLDEST_EN
    overwrite = drop;
`else
    overwrite = 1'b0;
`endif
    wr_en     = push || overwrite;
  end

  always_comb begin
    status             = '0;
    status[ADDR_W:0]   = level;
    status[16]         = empty;
    status[17]         = full;
    status[18]         = overflow;
    status[19]         = underflow;
    rd_mux             = '0;
    case (avs_address)
      2'd0:    rd_mux = empty ? 32'd0 : head[31:0];
      2'd1:    rd_mux = hi_hold;
      2'd2:    rd_mux = status;
      default: rd_mux = accepted_cnt;
    endcase
  end

  // Sample storage carries no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      accepted_cnt <= '0;
      hi_hold      <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      accepted_cnt <= '0;
      hi_hold      <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr       <= wr_ptr + PTR_ONE;
        accepted_cnt <= accepted_cnt + CNT_ONE;
      end
      if (pop || overwrite) rd_ptr <= rd_ptr + PTR_ONE;
      if (pop) hi_hold <= head[63:32];
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
      if (clr_flags) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (drop)  overflow  <= 1'b1;
        if (uflow) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      data_ready   <= 1'b0;
    end else begin
      data_ready <= (level >= HALF_LVL);
      if (avs_read) avs_readdata <= avs_write ? 32'd0 : rd_mux;
    end
  end

endmodule

// File: tb/tb_result_stream_reader.sv
// Scoreboard bench for result_stream_reader: samples queued on push, compared when drained via DATA_LO/DATA_HI.
module tb_result_stream_reader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        data_ready;

  result_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  int unsigned m_cnt = 0;
  logic        m_ov = 1'b0;
  logic        m_un = 1'b0;
  logic [31:0] m_hi = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(exp_q.size());
    s[16] = (exp_q.size() == 0);
    s[17] = (exp_q.size() == DEPTH);
    s[18] = m_ov;
    s[19] = m_un;
    return s;
  endfunction

  function automatic void m_clear();
    exp_q.delete();
    m_cnt = 0; m_ov = 1'b0; m_un = 1'b0; m_hi = '0;
  endfunction

  function automatic void m_push(input logic [63:0] d);
    if (!enable) return;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      m_cnt++;
    end else begin
      m_ov = 1'b1;
`ifdef RESULT_READER_DROP_OLDEST_EN
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      m_cnt++;
`endif
    end
  endfunction

  function automatic logic [31:0] m_pop_lo();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      m_un = 1'b1;
      return 32'd0;
    end
    e = exp_q.pop_front();
    m_hi = e[63:32];
    return e[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    data_in = d;
    data_in_valid = 1'b1;
    m_push(d);
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] rd);
    avs_address = a;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    rd = avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    if (a == 2'd3) begin
      if (d[0]) m_clear();
      if (d[1]) begin m_ov = 1'b0; m_un = 1'b0; end
    end
    tick();
    avs_write = 1'b0;
  endtask

  task automatic read_lo_chk(input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = m_pop_lo();
    bus_read(2'd0, rd);
    check_eq(tag, 64'(rd), 64'(exp));
  endtask

  task automatic read_hi_chk(input string tag);
    logic [31:0] rd;
    bus_read(2'd1, rd);
    check_eq(tag, 64'(rd), 64'(m_hi));
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] rd;
    bus_read(2'd2, rd);
    check_eq(tag, 64'(rd), 64'(m_status()));
  endtask

  task automatic count_chk(input string tag);
    logic [31:0] rd;
    bus_read(2'd3, rd);
    check_eq(tag, 64'(rd), 64'(m_cnt));
  endtask

  // Push and DATA_LO read in the same cycle; the model pops before it pushes.
  task automatic push_pop_chk(input string tag, input logic [63:0] d);
    logic [31:0] exp;
    exp = m_pop_lo();
    m_push(d);
    data_in = d;
    data_in_valid = 1'b1;
    avs_address = 2'd0;
    avs_read = 1'b1;
    tick();
    data_in_valid = 1'b0;
    avs_read = 1'b0;
    check_eq(tag, 64'(avs_readdata), 64'(exp));
  endtask

  initial begin
    logic [31:0] rd;
    repeat (3) tick();
    check_eq("reset_readdata", 64'(avs_readdata), 64'd0);
    check_eq("reset_data_ready", 64'(data_ready), 64'd0);
    reset_n = 1'b1;
    tick();
    status_chk("reset_status");
    check_eq("reset_status_const", 64'(m_status()), 64'h10000);

    // Basic order
    enable = 1'b1;
    push(64'h1111_2222_3333_4444);
    push(64'hAAAA_BBBB_CCCC_DDDD);
    read_lo_chk("basic_lo0");
    read_hi_chk("basic_hi0");
    read_lo_chk("basic_lo1");
    read_hi_chk("basic_hi1");
    check_eq("basic_hi1_const", 64'(m_hi), 64'hAAAABBBB);
    status_chk("basic_status_empty");

    // Underflow and flag clear
    read_lo_chk("underflow_lo");
    status_chk("underflow_status");
    bus_write(2'd3, 32'h2);
    status_chk("underflow_cleared");

    // Enable gating
    bus_write(2'd3, 32'h1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) push(64'(i) + 64'h55);
    status_chk("gated_status");
    count_chk("gated_count");

    // data_ready threshold
    enable = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) push(64'(i) << 8);
    check_eq("ready_not_yet", 64'(data_ready), 64'd0);
    tick();
    check_eq("ready_rises", 64'(data_ready), 64'd1);

    // Overflow: DEPTH+3 samples valued 0..258
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < DEPTH + 3; i++) push({32'(i) ^ 32'hF0F0_0000, 32'(i)});
    status_chk("ovf_status");
    count_chk("ovf_count");
    read_lo_chk("ovf_first_lo");
    read_hi_chk("ovf_first_hi");

    // Same-cycle push and pop while full
    bus_write(2'd3, 32'h2);
    push(64'hDEAD_0000_BEEF_0001);
    status_chk("full_again");
    push_pop_chk("full_pushpop_lo", 64'hDEAD_0000_BEEF_0002);
    status_chk("full_pushpop_status");

    // Read and write together: read returns 0, nothing changes
    avs_address = 2'd3;
    avs_writedata = 32'h0;
    avs_write = 1'b1;
    avs_read = 1'b1;
    tick();
    avs_write = 1'b0;
    avs_read = 1'b0;
    check_eq("rdwr_collision", 64'(avs_readdata), 64'd0);
    status_chk("rdwr_status");

    // Drain some entries through the scoreboard
    for (int i = 0; i < 6; i++) begin
      read_lo_chk("drain_lo");
      read_hi_chk("drain_hi");
    end

    // Same-cycle push and pop while empty: no fall-through
    bus_write(2'd3, 32'h1);
    push_pop_chk("empty_pushpop_lo", 64'h0123_4567_89AB_CDEF);
    status_chk("empty_pushpop_status");
    read_lo_chk("empty_pushpop_data");

    // Reset mid-stream
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < 50; i++) push(64'(i) | 64'h7700_0000_0000_0000);
    read_lo_chk("pre_reset_lo");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_clear();
    check_eq("midreset_readdata", 64'(avs_readdata), 64'd0);
    status_chk("midreset_status");
    read_hi_chk("midreset_hi");

    // Flush mid-stream
    for (int i = 0; i < 50; i++) push(64'(i) | 64'h6600_0000_0000_0000);
    read_lo_chk("pre_flush_lo");
    bus_write(2'd3, 32'h1);
    status_chk("flush_status");
    bus_read(2'd2, rd);
    check_eq("flush_status_const", 64'(rd), 64'h10000);
    count_chk("flush_count");
    read_hi_chk("flush_hi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
